// File: rtl/nv_nvdla_cdma_img_rd_req_sched.sv
// rtl/nv_nvdla_cdma_img_rd_req_sched.sv - credit-gated round-robin scheduler for the CDMA image read-request port
module nv_nvdla_cdma_img_rd_req_sched #(
  parameter int PD_W       = 79,
  parameter int CREDIT_MAX = 128,
  parameter int CNT_W      = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             req0_valid,
  input  logic [PD_W-1:0]  req0_pd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [PD_W-1:0]  req1_pd,
  output logic             req1_ready,
  output logic             dma_rd_req_vld,
  output logic [PD_W-1:0]  dma_rd_req_pd,
  output logic             dma_rd_req_src,
  input  logic             dma_rd_req_rdy,
  input  logic             rsp_pop,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             sched_idle,
  output logic             credit_err
);

  logic             r_vld;
  logic [PD_W-1:0]  r_pd;
  logic             r_src;
  logic             r_rr_ptr;
  logic [CNT_W-1:0] r_credit_cnt;
  logic             r_credit_err;

  logic [15:0]      w_need0;
  logic [15:0]      w_need1;
  logic [15:0]      w_need_win;
  logic [15:0]      w_cnt16;
  logic [15:0]      w_cnt_nxt;
  logic             w_slot_free;
  logic             w_any_valid;
  logic             w_winner;
  logic             w_grant;
  logic             w_overflow;
  logic             w_oversize;

  // Beat counts are size+1, widened to 16 bits so size=0x7fff cannot wrap.
  assign w_need0     = 16'(req0_pd[PD_W-1:64]) + 16'd1;
  assign w_need1     = 16'(req1_pd[PD_W-1:64]) + 16'd1;
  assign w_cnt16     = 16'(r_credit_cnt);
  assign w_slot_free = !r_vld || dma_rd_req_rdy;
  assign w_any_valid = req0_valid || req1_valid;

  // Winner selection: rr_ptr breaks ties, a lone requester always wins arbitration;
  // a winner short of credits blocks the other side so neither can starve.
  always_comb begin
    w_winner = 1'b0;
    if (req0_valid && req1_valid) begin
      w_winner = r_rr_ptr;
    end else if (req1_valid) begin
      w_winner = 1'b1;
    end
    w_need_win = w_winner ? w_need1 : w_need0;
    w_grant    = w_slot_free && w_any_valid && (w_cnt16 >= w_need_win);
  end

  assign req0_ready = w_grant && !w_winner;
  assign req1_ready = w_grant && w_winner;

  // A pop with a full pool has nowhere to go: it is dropped and flagged.
  assign w_overflow = rsp_pop && (r_credit_cnt == CNT_W'(CREDIT_MAX));
  assign w_oversize = (req0_valid && (w_need0 > 16'(CREDIT_MAX))) ||
                      (req1_valid && (w_need1 > 16'(CREDIT_MAX)));

  // Net credit change for this cycle: grant consumes need, pop returns one.
  always_comb begin
    w_cnt_nxt = w_cnt16;
    if (w_grant) begin
      w_cnt_nxt = w_cnt_nxt - w_need_win;
    end
    if (rsp_pop && !w_overflow) begin
      w_cnt_nxt = w_cnt_nxt + 16'd1;
    end
  end

  // Control state: output valid/source, arbitration pointer, credits, sticky error.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_vld        <= 1'b0;
      r_src        <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_credit_cnt <= CNT_W'(CREDIT_MAX);
      r_credit_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_vld    <= 1'b1;
        r_src    <= w_winner;
        r_rr_ptr <= ~w_winner;
      end else if (dma_rd_req_rdy) begin
        r_vld    <= 1'b0;
      end
      r_credit_cnt <= CNT_W'(w_cnt_nxt);
      if (w_overflow || w_oversize) begin
        r_credit_err <= 1'b1;
      end
    end
  end

  // Payload register carries no reset; it is only meaningful while r_vld is set.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_grant) begin
      r_pd <= w_winner ? req1_pd : req0_pd;
    end
  end

  assign dma_rd_req_vld = r_vld;
  assign dma_rd_req_pd  = r_pd;
  assign dma_rd_req_src = r_src;
  assign credit_cnt     = r_credit_cnt;
  assign credit_err     = r_credit_err;
  assign sched_idle     = !r_vld && (r_credit_cnt == CNT_W'(CREDIT_MAX));

endmodule

// File: tb/tb_nv_nvdla_cdma_img_rd_req_sched.sv
// tb/tb_nv_nvdla_cdma_img_rd_req_sched.sv - randomized and directed checks of the read-request scheduler
module tb_nv_nvdla_cdma_img_rd_req_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [78:0] req0_pd, req1_pd;
  logic        req0_ready, req1_ready;
  logic        dma_rd_req_vld;
  logic [78:0] dma_rd_req_pd;
  logic        dma_rd_req_src;
  logic        dma_rd_req_rdy;
  logic        rsp_pop;
  logic [7:0]  credit_cnt;
  logic        sched_idle;
  logic        credit_err;

  nv_nvdla_cdma_img_rd_req_sched dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .req0_valid      (req0_valid),
    .req0_pd         (req0_pd),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_pd         (req1_pd),
    .req1_ready      (req1_ready),
    .dma_rd_req_vld  (dma_rd_req_vld),
    .dma_rd_req_pd   (dma_rd_req_pd),
    .dma_rd_req_src  (dma_rd_req_src),
    .dma_rd_req_rdy  (dma_rd_req_rdy),
    .rsp_pop         (rsp_pop),
    .credit_cnt      (credit_cnt),
    .sched_idle      (sched_idle),
    .credit_err      (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: credit pool as an integer, "favoured requester", and the
  // single output slot as a held transaction.
  int          m_cnt;
  bit          m_fav;
  bit          m_vld;
  bit          m_src;
  bit          m_err;
  logic [78:0] m_pd;
  bit          last_g;
  bit          last_w;

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] make_pd(input int size);
    logic [78:0] p;
    p[63:0]  = {$urandom, $urandom};
    p[78:64] = 15'(size);
    return p;
  endfunction

  task automatic model_reset();
    m_cnt = 128; m_fav = 0; m_vld = 0; m_src = 0; m_err = 0; m_pd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; req0_pd = '0; req1_pd = '0;
    dma_rd_req_rdy = 0; rsp_pop = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // One clock: drive inputs, check DUT against model, then advance the model.
  task automatic step(input bit v0, input logic [78:0] p0, input bit v1, input logic [78:0] p1,
                      input bit rdy, input bit pop);
    int  need0, need1, need;
    bit  slot, w, g;
    @(negedge clk);
    req0_valid = v0; req0_pd = p0; req1_valid = v1; req1_pd = p1;
    dma_rd_req_rdy = rdy; rsp_pop = pop;
    #1;
    need0 = int'(p0[78:64]) + 1;
    need1 = int'(p1[78:64]) + 1;
    slot  = !m_vld || rdy;
    w     = (v0 && v1) ? m_fav : v1;
    need  = w ? need1 : need0;
    g     = slot && (v0 || v1) && (m_cnt >= need);
    chk("req0_ready", req0_ready, g && !w);
    chk("req1_ready", req1_ready, g && w);
    chk("out_vld", dma_rd_req_vld, m_vld);
    chk("out_src", dma_rd_req_src, m_src);
    if (m_vld) chk("out_pd", dma_rd_req_pd, m_pd);
    chk("credit_cnt", credit_cnt, m_cnt);
    chk("sched_idle", sched_idle, !m_vld && m_cnt == 128);
    chk("credit_err", credit_err, m_err);
    if ((v0 && need0 > 128) || (v1 && need1 > 128)) m_err = 1;
    if (pop && m_cnt == 128) m_err = 1;
    if (g) begin
      m_vld = 1; m_src = w; m_pd = w ? p1 : p0; m_fav = !w; m_cnt -= need;
    end else if (rdy) begin
      m_vld = 0;
    end
    if (pop && (m_cnt + (g ? need : 0)) != 128) m_cnt += 1;
    last_g = g; last_w = w;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [78:0] hold_pd;
  bit          pend0, pend1;
  logic [78:0] q0, q1;
  bit          r1_seen;

  initial begin
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; req0_pd = '0; req1_pd = '0;
    dma_rd_req_rdy = 0; rsp_pop = 0;
    model_reset();

    // T1: reset state
    do_reset();
    #1;
    chk("t1_vld", dma_rd_req_vld, 0);
    chk("t1_cnt", credit_cnt, 128);
    chk("t1_idle", sched_idle, 1);
    chk("t1_err", credit_err, 0);
    chk("t1_r0", req0_ready, 0);
    chk("t1_r1", req1_ready, 0);

    // T2: alternating round-robin at full throughput
    for (int i = 0; i < 4; i++) begin
      step(1, make_pd(0), 1, make_pd(0), 1, 0);
      chk("t2_grant", last_g, 1);
      chk("t2_winner", last_w, i % 2);
    end
    after_edge();
    chk("t2_cnt", credit_cnt, 124);
    chk("t2_src", dma_rd_req_src, 1);

    // T3: RR winner short of credits blocks both sides until pops refill
    do_reset();
    step(0, '0, 1, make_pd(119), 1, 0);
    q0 = make_pd(15);
    q1 = make_pd(0);
    step(1, q0, 1, q1, 1, 0);
    chk("t3_blocked", last_g, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, q0, 1, q1, 1, 1);
      chk("t3_wait", last_g, 0);
    end
    step(1, q0, 1, q1, 1, 0);
    chk("t3_grant", last_g, 1);
    chk("t3_winner", last_w, 0);
    after_edge();
    chk("t3_cnt", credit_cnt, 0);

    // T4: back-pressure holds output, accept plus grant is back-to-back
    do_reset();
    hold_pd = make_pd(3);
    step(1, hold_pd, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, make_pd(1), 1, make_pd(2), 0, 0);
      chk("t4_nogrant", last_g, 0);
      chk("t4_pd_hold", dma_rd_req_pd, hold_pd);
    end
    step(1, make_pd(1), 1, make_pd(2), 1, 0);
    chk("t4_regrant", last_g, 1);
    after_edge();
    chk("t4_vld", dma_rd_req_vld, 1);

    // T5: grant and pop in the same cycle net out; pop into a full pool flags
    do_reset();
    step(1, make_pd(117), 0, '0, 1, 0);
    step(0, '0, 1, make_pd(3), 1, 1);
    after_edge();
    chk("t5_net", credit_cnt, 7);
    do_reset();
    step(0, '0, 0, '0, 1, 1);
    after_edge();
    chk("t5_ovf_cnt", credit_cnt, 128);
    chk("t5_ovf_err", credit_err, 1);

    // T6: oversize request flags and never gets granted; async reset mid-transfer
    do_reset();
    r1_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 1, make_pd(200), 1, 0);
      if (req1_ready) r1_seen = 1;
    end
    chk("t6_never_ready", r1_seen, 0);
    after_edge();
    chk("t6_err", credit_err, 1);
    do_reset();
    step(1, make_pd(9), 0, '0, 0, 0);
    after_edge();
    chk("t6_vld_before", dma_rd_req_vld, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_vld", dma_rd_req_vld, 0);
    chk("t6_rst_cnt", credit_cnt, 128);
    model_reset();
    @(negedge clk);
    req0_valid = 0;
    rst_n = 1;

    // Randomized traffic against the model
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend0 && ($urandom % 3 == 0)) begin
        pend0 = 1;
        q0 = make_pd(($urandom % 8 == 0) ? $urandom_range(16, 127) : $urandom_range(0, 15));
      end
      if (!pend1 && ($urandom % 3 == 0)) begin
        pend1 = 1;
        q1 = make_pd(($urandom % 8 == 0) ? $urandom_range(16, 127) : $urandom_range(0, 15));
      end
      step(pend0, pend0 ? q0 : make_pd(0), pend1, pend1 ? q1 : make_pd(0),
           ($urandom % 4) != 0, (m_cnt < 128) && ($urandom % 2 == 1));
      if (last_g && !last_w) pend0 = 0;
      if (last_g && last_w)  pend1 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
